// File: rtl/ex_mem_skid_pkg.sv
// EX/MEM skid register: shared widths, NOP values and state encoding.
// Imported by the interface and the stage.
package ex_mem_skid_pkg;

  localparam int RegBus           = 32;
  localparam int RegAddrBus       = 5;
  localparam int EX_MEM_PAYLOAD_W = 8;

  localparam logic RstEnable    = 1'b1;
  localparam logic WriteDisable = 1'b0;

  localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;
  localparam logic [RegBus-1:0]     ZeroWord   = '0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/ex_mem_skid_if.sv
// Valid/ready bundle carrying one EX/MEM entry.
// master drives the entry, slave drives ready.
interface ex_mem_skid_if
  import ex_mem_skid_pkg::*;
#(
  parameter int DATA_W    = RegBus,
  parameter int ADDR_W    = RegAddrBus,
  parameter int PAYLOAD_W = EX_MEM_PAYLOAD_W
) ();

  logic                 valid;
  logic                 ready;
  logic [ADDR_W-1:0]    wd;
  logic                 wreg;
  logic [DATA_W-1:0]    wdata;
  logic [PAYLOAD_W-1:0] payload;

  modport master (
    output valid, wd, wreg, wdata, payload,
    input  ready
  );

  modport slave (
    input  valid, wd, wreg, wdata, payload,
    output ready
  );

endinterface

// File: rtl/ex_mem_skid.sv
// EX/MEM pipeline register with registered ready and a one-entry skid.
// FIFO order; flush and rst drop everything held.
module ex_mem_skid
  import ex_mem_skid_pkg::*;
#(
  parameter int DATA_W    = RegBus,
  parameter int ADDR_W    = RegAddrBus,
  parameter int PAYLOAD_W = EX_MEM_PAYLOAD_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  ex_mem_skid_if.slave       ex,
  ex_mem_skid_if.master      mem,
  output logic [1:0]         occupancy
);

  localparam int ENT_W = ADDR_W + 1 + DATA_W + PAYLOAD_W;

  localparam logic [ENT_W-1:0] NOP_ENT = {
    ADDR_W'(NOPRegAddr),
    WriteDisable,
    DATA_W'(ZeroWord),
    PAYLOAD_W'(0)
  };

  skid_state_e state_q, state_n;
  logic        ready_q;
  logic        kill;
  logic        accept, drain;
  logic        ld_main_ex, ld_main_skid, ld_skid;
  logic        main_wreg;

  logic [ENT_W-1:0] main_q, skid_q, ex_ent;

  assign kill   = (rst == RstEnable) | flush;
  assign ex_ent = {ex.wd, ex.wreg, ex.wdata, ex.payload};
  assign accept = ex.valid & ready_q;
  assign drain  = mem.valid & mem.ready;

  // ready only tracks the next state, so MEM never reaches EX combinationally
  always_ff @(posedge clk) begin
    state_q <= state_n;
    ready_q <= (state_n != FULL);
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      EMPTY: if (accept) state_n = ONE;
      ONE: begin
        if (accept && !drain)      state_n = FULL;
        else if (!accept && drain) state_n = EMPTY;
      end
      FULL:  if (drain) state_n = ONE;
      default: state_n = EMPTY;
    endcase
    if (kill) state_n = EMPTY;
  end

  always_comb begin
    ld_main_ex   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    unique case (1'b1)
      state_q == EMPTY: ld_main_ex = accept;
      state_q == ONE: begin
        ld_main_ex = accept & drain;
        ld_skid    = accept & ~drain;
      end
      state_q == FULL: ld_main_skid = drain;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      main_q <= NOP_ENT;
      skid_q <= NOP_ENT;
    end else begin
      if (ld_main_ex)        main_q <= ex_ent;
      else if (ld_main_skid) main_q <= skid_q;
      if (ld_skid)           skid_q <= ex_ent;
    end
  end

  assign ex.ready    = ready_q;
  assign mem.valid   = (state_q != EMPTY);
  assign occupancy   = state_q;
  assign {mem.wd, main_wreg, mem.wdata, mem.payload} = main_q;
  assign mem.wreg    = mem.valid & main_wreg;

endmodule

// File: doc/ex_mem_skid.md
Name: ex_mem_skid

Overview:
Parametrised EX/MEM pipeline register with valid/ready handshake and a one-entry skid buffer. It replaces the plain always-advance EX/MEM latch. It carries the destination register address, write enable, write data and a generic side payload (mem op, address, HI/LO, etc.) from EX to MEM. It supports back-pressure from MEM (multi-cycle memory), a pipeline flush, and a registered in_ready, so no combinational ready path runs from MEM back to EX.

Parameters:
DATA_W, 32, width of write data (RegBus)
ADDR_W, 5, width of destination register address (RegAddrBus)
PAYLOAD_W, 8, width of opaque side payload; minimum 1

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  reset, synchronous, active-high
flush  in  1  discard all held entries (exception/branch squash)
ex_valid  in  1  EX presents a valid instruction
ex_ready  out  1  stage can accept; registered
ex_wd  in  ADDR_W  destination register address
ex_wreg  in  1  register write enable
ex_wdata  in  DATA_W  register write data
ex_payload  in  PAYLOAD_W  side payload
mem_valid  out  1  MEM-side entry valid
mem_ready  in  1  MEM consumes the entry this cycle
mem_wd  out  ADDR_W  head entry address
mem_wreg  out  1  head entry write enable, gated by mem_valid
mem_wdata  out  DATA_W  head entry data
mem_payload  out  PAYLOAD_W  head entry payload
occupancy  out  2  number of held entries, 0..2

Behaviour:
- Storage: main entry (drives mem_*) and skid entry; each has a valid bit plus {wd, wreg, wdata, payload}.
- States: EMPTY (none valid), ONE (main valid), FULL (main and skid valid). Skid never valid without main.
- accept = ex_valid & ex_ready; drain = mem_valid & mem_ready.
- ex_ready is a register: 1 in EMPTY and ONE, 0 in FULL; it updates with the state.
- EMPTY: accept -> load main, go to ONE.
- ONE, accept & drain -> main <= EX, stay ONE.
- ONE, accept & !drain -> skid <= EX, go to FULL.
- ONE, !accept & drain -> EMPTY.
- ONE, neither -> hold.
- FULL (no accept possible): drain -> main <= skid, skid invalid, go to ONE; otherwise hold.
- Order is strictly FIFO; no entry is lost or duplicated.
- Latency: 1 cycle from accept to mem_valid when empty. Throughput: 1/cycle while mem_ready=1.
- mem_wreg = main_valid & main_wreg, so a bubble never writes the register file.
- When main is invalid, the mem_wd/mem_wdata/mem_payload values are don't-care for consumers. They are driven to NOPRegAddr/ZeroWord/0 on reset and flush.
- flush (takes priority over accept and drain): next cycle state=EMPTY, both valid bits 0, ex_ready=1, data fields to NOP values. The EX input presented in the flush cycle is dropped.
- rst: same end state as flush, plus mem_wreg=WriteDisable, occupancy=0, ex_ready=1 (in the cycle after rst is sampled). rst mid-transfer discards all held entries.
- While rst is held: ex_ready=1 but no accept occurs (rst dominates).
- occupancy: EMPTY=0, ONE=1, FULL=2.
- With mem_ready stuck at 1, behaviour is cycle-equivalent to the old always-advance latch.
- ex_payload is never interpreted; it is passed bit-exact.

Decomposition:
- Shared defines file: RstEnable, WriteDisable, NOPRegAddr, ZeroWord, RegBus/RegAddrBus widths.
- New constants there: EX_MEM_PAYLOAD_W default and state encodings EMPTY=2'd0, ONE=2'd1, FULL=2'd2.
- Single module; no sub-module warranted. The entry record is a packed concatenation {wd, wreg, wdata, payload} reused for main and skid.

Test Plan:
- Reset: assert rst 2 cycles with ex_valid=1 -> mem_valid=0, mem_wreg=0, mem_wd=0, mem_wdata=0, ex_ready=1, occupancy=0.
- Streaming: mem_ready=1; send wd=1..8, wdata=0x11..0x88 on consecutive cycles -> same sequence on mem_* 1 cycle later, ex_ready constantly 1.
- Back-pressure: send A(wd=3, 0xAAAA) and B(wd=4, 0xBBBB) with mem_ready=0 -> occupancy=2, ex_ready=0. Send C while blocked -> C not taken. Raise mem_ready -> A, B, C drain in order, ex_ready returns to 1.
- Flush when FULL, with ex_valid=1 carrying D -> next cycle mem_valid=0, occupancy=0, ex_ready=1; D never appears at MEM.
- Bubble gating: ex_valid=1 with ex_wreg=1, then ex_valid=0 -> mem_wreg=1 for one cycle then 0, never 1 while mem_valid=0.
- Random valid/ready with scoreboard (payload=8'h5A tags, 10k cycles) -> output order equals input order, no drops or duplicates.
